// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption core: owns the cipher state and applies one full round per clock.
// Latency: NR cycles from the start edge to the oValid pulse; one block every NR+1 cycles.
// Backpressure: none; iStart is ignored while oBusy is high and the requester must wait for it to fall.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic [127:0] iData,
    input  logic [127:0] iRoundKey,
    output logic [3:0]   oKeyIdx,
    output logic         oBusy,
    output logic         oValid,
    output logic [127:0] oData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_e;

    localparam logic [3:0] LAST_RND = 4'(NR - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    // GF(2^8) multiply by x, reduced by the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte k of the state (k = row + 4*col) lives at [127-8k -: 8].
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    // Each column multiplied by the fixed circulant {02,03,01,01}.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    fsm_e         fsm_q,   fsm_d;
    logic [3:0]   rnd_q,   rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] data_q,  data_d;
    logic         valid_q, valid_d;
    logic         busy_q,  busy_d;

    logic [127:0] sb_w;
    logic [127:0] sr_w;
    logic [127:0] mc_w;

    // Round datapath; the final round taps sr_w so MixColumns is skipped there.
    always_comb begin
        sb_w = sub_bytes(state_q);
        sr_w = shift_rows(sb_w);
        mc_w = mix_columns(sr_w);
    end

    // Next-state logic for the FSM, round counter, cipher state and output register.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (iStart) begin
                    state_d = iData ^ iRoundKey;
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = mc_w ^ iRoundKey;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) fsm_d = FINAL;
            end
            FINAL: begin
                data_d  = sr_w ^ iRoundKey;
                valid_d = 1'b1;
                rnd_d   = 4'd0;
                fsm_d   = IDLE;
            end
            default: begin
                fsm_d = IDLE;
                rnd_d = 4'd0;
            end
        endcase
        busy_d = (fsm_d != IDLE);
    end

    // Key index decode; depends only on flops so it settles once per cycle for a key RAM read.
    always_comb begin
        oKeyIdx = 4'd0;
        case (fsm_q)
            ROUND:   oKeyIdx = rnd_q;
            FINAL:   oKeyIdx = NR_IDX;
            default: oKeyIdx = 4'd0;
        endcase
    end

    // All state and registered outputs; reset discards any in-flight block.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign oBusy  = busy_q;
    assign oValid = valid_q;
    assign oData  = data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: FIPS-197 vectors, busy rejection, back-to-back, reset mid-round, idle hold.
// Round keys are expanded by the bench and served combinationally by oKeyIdx.
// Expected ciphertexts and their due cycle go into a queue; a negedge monitor pops on oValid.
module tb_aes_round_ctrl;

    logic         iClk;
    logic         iRst_n;
    logic         iStart;
    logic [127:0] iData;
    logic [127:0] iRoundKey;
    logic [3:0]   oKeyIdx;
    logic         oBusy;
    logic         oValid;
    logic [127:0] oData;

    aes_round_ctrl #(.NR(10)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iData     (iData),
        .iRoundKey (iRoundKey),
        .oKeyIdx   (oKeyIdx),
        .oBusy     (oBusy),
        .oValid    (oValid),
        .oData     (oData)
    );

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         got_e;
    logic [7:0]   sbox_t [0:255];
    logic [127:0] rks [0:1][0:10];
    int           key_sel;
    int           cyc;
    int           n_checks;
    int           n_fail;

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    always @(posedge iClk) cyc <= cyc + 1;

    always_comb begin
        iRoundKey = '0;
        if (oKeyIdx <= 4'd10) iRoundKey = rks[key_sel][oKeyIdx];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every oValid must match the oldest outstanding expectation, on its due cycle.
    always @(negedge iClk) begin
        if (oValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got oValid=1 with oData=%h, required no pulse (cycle %0d)", oData, cyc);
            end else begin
                got_e = exp_q.pop_front();
                chk("ciphertext", oData, got_e.data);
                chk("valid_cycle", 128'(cyc), 128'(got_e.cyc));
            end
        end
    end

    // S-box table built from the generator-3 power cycle (independent of any inverse routine).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    task automatic expand(input int set, input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc   = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) begin
            rks[set][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        end
    endtask

    // Called in the start cycle (at a negedge); returns at the negedge of cycle 0 after the start edge.
    task automatic start_block(input logic [127:0] pt, input int set, input logic [127:0] ct);
        exp_t e;
        key_sel = set;
        iData   = pt;
        iStart  = 1'b1;
        @(negedge iClk);
        iStart  = 1'b0;
        iData   = $urandom();
        e.data  = ct;
        e.cyc   = cyc + 10;
        exp_q.push_back(e);
    endtask

    // From cycle 0, walk to cycle 10 checking busy (and optionally the key index) each cycle.
    task automatic watch(input bit chk_idx);
        for (int j = 0; j < 10; j++) begin
            chk("busy_in_flight", 128'(oBusy), 128'd1);
            if (chk_idx) chk("key_idx", 128'(oKeyIdx), 128'(j + 1));
            @(negedge iClk);
        end
        chk("busy_valid_cycle", 128'(oBusy), 128'd0);
        chk("key_idx_valid_cycle", 128'(oKeyIdx), 128'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        key_sel  = 0;
        iStart   = 1'b0;
        iData    = '0;
        iRst_n   = 1'b0;
        build_sbox();
        expand(0, KEY_B);
        expand(1, KEY_C);

        // Reset state.
        @(negedge iClk);
        chk("rst_busy", 128'(oBusy), 128'd0);
        chk("rst_valid", 128'(oValid), 128'd0);
        chk("rst_data", oData, 128'd0);
        chk("rst_key_idx", 128'(oKeyIdx), 128'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);

        // FIPS-197 App. B.
        start_block(PT_B, 0, CT_B);
        watch(1'b1);

        // FIPS-197 App. C.1 with the full key-index trace.
        @(negedge iClk);
        chk("c1_key_idx_start", 128'(oKeyIdx), 128'd0);
        start_block(PT_C, 1, CT_C);
        watch(1'b1);

        // Idle hold.
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            chk("idle_data", oData, CT_C);
            chk("idle_valid", 128'(oValid), 128'd0);
            chk("idle_key_idx", 128'(oKeyIdx), 128'd0);
        end

        // Busy rejection: extra starts at cycles 3 and 9 with other plaintext.
        @(negedge iClk);
        start_block(PT_B, 0, CT_B);
        repeat (3) @(negedge iClk);
        iStart = 1'b1;
        iData  = PT_C;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (5) @(negedge iClk);
        iStart = 1'b1;
        iData  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        @(negedge iClk);
        iStart = 1'b0;
        chk("reject_busy_valid_cycle", 128'(oBusy), 128'd0);
        repeat (14) @(negedge iClk);
        chk("reject_idle_busy", 128'(oBusy), 128'd0);

        // Back-to-back: second start in the oValid cycle of the first.
        start_block(PT_B, 0, CT_B);
        watch(1'b0);
        start_block(PT_C, 1, CT_C);
        watch(1'b0);

        // Reset mid-round at cycle 5, then a clean App. B run.
        @(negedge iClk);
        start_block(PT_B, 0, CT_B);
        repeat (5) @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(oBusy), 128'd0);
        chk("midrst_valid", 128'(oValid), 128'd0);
        chk("midrst_data", oData, 128'd0);
        chk("midrst_key_idx", 128'(oKeyIdx), 128'd0);
        exp_q.delete();
        repeat (3) @(negedge iClk);
        chk("midrst_hold_valid", 128'(oValid), 128'd0);
        iRst_n = 1'b1;
        repeat (8) @(negedge iClk);
        chk("post_rst_idle_valid", 128'(oValid), 128'd0);
        start_block(PT_B, 0, CT_B);
        watch(1'b1);

        repeat (15) @(negedge iClk);
        chk("outstanding_blocks", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
